// File: rtl/iter_divider.sv
// rtl/iter_divider.sv - restoring radix-2 iterative divider (DIV/DIVU/REM/REMU), valid/ready in and out.
// Optional early-out for B==0 / |B|==1 / signed overflow: define DIV_SPECIAL_BYPASS_EN.
module iter_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             is_signed,
    input  logic             want_rem,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             DivByZero
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t state, state_nxt;

    // dvd holds the dividend magnitude and collects quotient bits as it shifts out
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] a_orig;
    logic [CNT_W-1:0] count;
    logic             sign_q;
    logic             sign_r;
    logic             rem_sel;
    logic             dbz;

    logic             accept;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_diff;
    logic             can_sub;
    logic             last_step;
    logic [WIDTH-1:0] q_fin;
    logic [WIDTH-1:0] r_fin;
    logic [WIDTH-1:0] res_fin;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    assign mag_a = (is_signed && A[WIDTH-1]) ? (~A + 1'b1) : A;
    assign mag_b = (is_signed && B[WIDTH-1]) ? (~B + 1'b1) : B;

    // remainder is always below the divisor, so a borrow in the top bit means "does not fit"
    assign rem_shift = {rem, dvd[WIDTH-1]};
    assign rem_diff  = rem_shift - {1'b0, dvs};
    assign can_sub   = !rem_diff[WIDTH];
    assign last_step = (count == CNT_W'(WIDTH - 1));

    assign q_fin   = dbz ? {WIDTH{1'b1}} : (sign_q ? (~dvd + 1'b1) : dvd);
    assign r_fin   = dbz ? a_orig : (sign_r ? (~rem + 1'b1) : rem);
    assign res_fin = rem_sel ? r_fin : q_fin;

`ifdef DIV_SPECIAL_BYPASS_EN
    // |B|==1 leaves the quotient magnitude equal to |A| with zero remainder, which is
    // exactly what the accept edge loads, so FIX can finish the op directly.
    logic special;
    assign special = (B == '0) || (mag_b == WIDTH'(1));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef DIV_SPECIAL_BYPASS_EN
                    state_nxt = special ? FIX : CALC;
`else
                    state_nxt = CALC;
`endif
                end
            end
            CALC: begin
                if (last_step) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                state_nxt = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd       <= '0;
            dvs       <= '0;
            rem       <= '0;
            a_orig    <= '0;
            count     <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            rem_sel   <= 1'b0;
            dbz       <= 1'b0;
            Result    <= '0;
            Zero      <= 1'b1;
            DivByZero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        dvd     <= mag_a;
                        dvs     <= mag_b;
                        rem     <= '0;
                        a_orig  <= A;
                        count   <= '0;
                        sign_q  <= is_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
                        sign_r  <= is_signed && A[WIDTH-1];
                        rem_sel <= want_rem;
                        dbz     <= (B == '0);
                    end
                end
                CALC: begin
                    dvd   <= {dvd[WIDTH-2:0], can_sub};
                    rem   <= can_sub ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
                    count <= count + 1'b1;
                end
                FIX: begin
                    Result    <= res_fin;
                    Zero      <= (res_fin == '0);
                    DivByZero <= dbz;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iter_divider.sv
// tb/tb_iter_divider.sv - vector table, random ops against SV arithmetic, backpressure and async-reset sequences.
module tb_iter_divider;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        is_signed = 1'b0;
    logic        want_rem = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] Result;
    logic        Zero;
    logic        DivByZero;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic        r;
        logic [31:0] res;
        logic        z;
        logic        d;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        d;
        int          lat;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[17];

    iter_divider #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .is_signed(is_signed), .want_rem(want_rem),
        .out_valid(out_valid), .out_ready(out_ready),
        .Result(Result), .Zero(Zero), .DivByZero(DivByZero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit bypass_expected(input logic [31:0] b, input logic s);
`ifdef DIV_SPECIAL_BYPASS_EN
        return (b == 32'd0) || (b == 32'd1) || (s && b == 32'hFFFF_FFFF);
`else
        return 1'b0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic collect(input int edges);
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk("result", Result, e.res);
        chk("zero", 32'(Zero), 32'(e.z));
        chk("divbyzero", 32'(DivByZero), 32'(e.d));
        chk("latency", 32'(edges), 32'(e.lat));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("out_valid_after_pop", 32'(out_valid), 32'd0);
        chk("in_ready_after_pop", 32'(in_ready), 32'd1);
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s, input logic r,
                         input logic [31:0] res, input logic z, input logic d);
        exp_t e;
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        A = a; B = b; is_signed = s; want_rem = r; in_valid = 1'b1;
        e.res = res; e.z = z; e.d = d;
        e.lat = bypass_expected(b, s) ? 1 : 33;
        sb.push_back(e);
        tick();
        in_valid = 1'b0;
        A = $urandom; B = $urandom; is_signed = ~s; want_rem = ~r;
    endtask

    task automatic wait_out(output int edges);
        edges = 0;
        while (!out_valid && edges < 200) begin
            tick();
            edges++;
        end
        if (!out_valid) chk("timeout", 32'd0, 32'd1);
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s, input logic r,
                         input logic [31:0] res, input logic z, input logic d);
        int edges;
        issue(a, b, s, r, res, z, d);
        wait_out(edges);
        if (out_valid) collect(edges);
        else void'(sb.pop_front());
    endtask

    initial begin
        int edges;
        logic [31:0] ra, rb, rres;
        logic rs, rr;

        vecs[0]  = '{32'd100, 32'd7, 1'b0, 1'b0, 32'd14, 1'b0, 1'b0};
        vecs[1]  = '{32'd100, 32'd7, 1'b0, 1'b1, 32'd2, 1'b0, 1'b0};
        vecs[2]  = '{-32'sd100, 32'd7, 1'b1, 1'b0, 32'hFFFF_FFF2, 1'b0, 1'b0};
        vecs[3]  = '{-32'sd100, 32'd7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[4]  = '{32'd7, -32'sd100, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0};
        vecs[5]  = '{32'd7, -32'sd100, 1'b1, 1'b1, 32'd7, 1'b0, 1'b0};
        vecs[6]  = '{32'h1234, 32'd0, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1};
        vecs[7]  = '{32'h1234, 32'd0, 1'b0, 1'b1, 32'h1234, 1'b0, 1'b1};
        vecs[8]  = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b0};
        vecs[9]  = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'd0, 1'b1, 1'b0};
        vecs[10] = '{32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[11] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd1, 1'b0, 1'b0};
        vecs[12] = '{-32'sd7, 32'd2, 1'b1, 1'b0, 32'hFFFF_FFFD, 1'b0, 1'b0};
        vecs[13] = '{-32'sd7, 32'd2, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[14] = '{32'h8000_0000, 32'd3, 1'b0, 1'b0, 32'h2AAA_AAAA, 1'b0, 1'b0};
        vecs[15] = '{32'h8000_0000, 32'd2, 1'b1, 1'b0, 32'hC000_0000, 1'b0, 1'b0};
        vecs[16] = '{-32'sd5, 32'd0, 1'b1, 1'b1, 32'hFFFF_FFFB, 1'b0, 1'b1};

        repeat (3) tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", Result, 32'd0);
        chk("rst_zero", 32'(Zero), 32'd1);
        chk("rst_divbyzero", 32'(DivByZero), 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 17; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].r, vecs[i].res, vecs[i].z, vecs[i].d);
        end

        for (int i = 0; i < 10; i++) begin
            ra = $urandom;
            rb = 32'($urandom_range(2, 5000));
            rs = 1'($urandom_range(0, 1));
            rr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) rb = -rb;
            if (rs) rres = rr ? 32'($signed(ra) % $signed(rb)) : 32'($signed(ra) / $signed(rb));
            else    rres = rr ? (ra % rb) : (ra / rb);
            do_op(ra, rb, rs, rr, rres, rres == 32'd0, 1'b0);
        end

        // backpressure: hold the result, ignore in_valid while DONE
        issue(32'd100, 32'd7, 1'b0, 1'b0, 32'd14, 1'b0, 1'b0);
        wait_out(edges);
        chk("bp_latency", 32'(edges), 32'd33);
        for (int i = 0; i < 10; i++) begin
            A = $urandom; B = 32'd3; in_valid = 1'(i % 2);
            tick();
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_result", Result, 32'd14);
        end
        in_valid = 1'b0;
        collect(33);
        do_op(32'd1000, 32'd10, 1'b0, 1'b0, 32'd100, 1'b0, 1'b0);

        // async reset in the middle of CALC drops the op
        A = 32'd100; B = 32'd7; is_signed = 1'b0; want_rem = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        chk("mid_calc_busy", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_result", Result, 32'd0);
        chk("arst_zero", 32'(Zero), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();
        do_op(-32'sd100, 32'd7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
